// File: rtl/bin_to_bcd_display_pkg.sv
// Shared constants for the binary-to-BCD display path: segment codes,
// FSM state encoding and the BCD digit width.
package bin_to_bcd_display_pkg;
  localparam int BCD_W = 4;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bin_to_bcd_display_seg7_decode.sv
// One BCD digit plus blank flag to active-low 7-segment pattern.
// Non-decimal nibbles show as blank.
module seg7_decode
  import bin_to_bcd_display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             blank,
  output logic [6:0]       seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end
endmodule

// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble converter: one shift/add-3 step per clock,
// result latched to bcd_out and HEX0..2 only when the conversion completes.
module bin_to_bcd_display
  import bin_to_bcd_display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic [6:0]              HEX0,
  output logic [6:0]              HEX1,
  output logic [6:0]              HEX2
);
  localparam int IW = $clog2(WIDTH + 1);
  localparam int CW = BCD_W * DIGITS + WIDTH;

  state_t                        state, state_nx;
  logic [WIDTH-1:0]              sreg;
  logic [DIGITS-1:0][BCD_W-1:0]  scr, scr_adj;
  logic [IW-1:0]                 iter;
  logic [CW-1:0]                 shifted;
  logic [DIGITS-1:0]             blank;
  logic [DIGITS-1:0][6:0]        seg, hex_q;
  logic                          seen;

  // Each digit adjusts independently in 4 bits; the shift carries the MSB up.
  always_comb begin
    scr_adj = scr;
    for (int k = 0; k < DIGITS; k++)
      if (scr[k] >= 4'd5) scr_adj[k] = scr[k] + 4'd3;
  end

  assign shifted = {scr_adj, sreg} << 1;

  always_comb begin
    seen  = 1'b0;
    blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seen     = seen | (scr[k] != '0);
      blank[k] = (BLANK_LZ != 0) && (k != 0) && !seen;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (.bcd(scr[g]), .blank(blank[g]), .seg(seg[g]));
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SHIFT;
      ST_SHIFT: if (iter == IW'(1)) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= ST_IDLE;
      done    <= 1'b0;
      bcd_out <= '0;
      hex_q   <= {DIGITS{SEG_BLANK}};
      sreg    <= '0;
      scr     <= '0;
      iter    <= '0;
    end else begin
      state <= state_nx;
      done  <= (state == ST_DONE);
      case (state)
        ST_IDLE: if (start) begin
          sreg <= bin_in;
          scr  <= '0;
          iter <= IW'(WIDTH);
        end
        ST_SHIFT: begin
          {scr, sreg} <= shifted;
          iter        <= iter - IW'(1);
        end
        ST_DONE: begin
          bcd_out <= scr;
          hex_q   <= seg;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Self-checking bench for bin_to_bcd_display: fixed vectors, handshake corner
// cases, exhaustive sweep and random conversions against a decimal model.
module tb_bin_to_bcd_display;
  logic        CLOCK_50 = 1'b0;
  logic        reset, start;
  logic [7:0]  bin_in;
  logic        busy, done;
  logic [11:0] bcd_out;
  logic [6:0]  HEX0, HEX1, HEX2;

  int cmp_cnt = 0, err_cnt = 0, done_cnt = 0, start_cnt = 0;

  bin_to_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(negedge CLOCK_50) if (done) done_cnt++;

  typedef struct {
    int          v;
    logic [11:0] bcd;
    logic [6:0]  h2, h1, h0;
  } vec_t;

  // Decimal reference: digits by division, blanking by magnitude.
  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tab [10];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tab[d];
  endfunction

  function automatic logic [6:0] ref_hex(input int v, input int k);
    int p;
    p = (k == 0) ? 1 : (k == 1) ? 10 : 100;
    if (k > 0 && v < p) return 7'b1111111;
    return seg_of((v / p) % 10);
  endfunction

  function automatic logic [32:0] ref_all(input int v);
    logic [11:0] b;
    b = 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
    return {ref_hex(v, 2), ref_hex(v, 1), ref_hex(v, 0), b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLOCK_50); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  // Start v, scramble bin_in after acceptance, wait for done and check result.
  task automatic convert(input int v, input string name);
    int lat;
    @(negedge CLOCK_50); start = 1'b1; bin_in = 8'(v);
    @(posedge CLOCK_50); #1;
    start = 1'b0; bin_in = 8'($urandom_range(0, 255)); start_cnt++;
    wait_done(lat);
    chk({name, " latency"}, 64'(lat), 64'd9);
    chk({name, " result"}, 64'({HEX2, HEX1, HEX0, bcd_out}), 64'(ref_all(v)));
  endtask

  initial begin
    vec_t vt [6];
    int   lat, dc;
    vt[0] = '{255, 12'h255, 7'b0100100, 7'b0010010, 7'b0010010};
    vt[1] = '{100, 12'h100, 7'b1111001, 7'b1000000, 7'b1000000};
    vt[2] = '{0,   12'h000, 7'b1111111, 7'b1111111, 7'b1000000};
    vt[3] = '{7,   12'h007, 7'b1111111, 7'b1111111, 7'b1111000};
    vt[4] = '{42,  12'h042, 7'b1111111, 7'b0011001, 7'b0100100};
    vt[5] = '{13,  12'h013, 7'b1111111, 7'b1111001, 7'b0110000};

    reset = 1'b1; start = 1'b0; bin_in = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset state", 64'({busy, done, bcd_out, HEX2, HEX1, HEX0}),
        64'({1'b0, 1'b0, 12'h000, 7'h7f, 7'h7f, 7'h7f}));
    @(negedge CLOCK_50); reset = 1'b0;

    // Fixed vectors with hand-computed expectations.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50); start = 1'b1; bin_in = 8'(vt[i].v);
      @(posedge CLOCK_50); #1; start = 1'b0; start_cnt++;
      chk("busy after accept", 64'(busy), 64'd1);
      wait_done(lat);
      chk("vec latency", 64'(lat), 64'd9);
      chk("vec bcd_out", 64'(bcd_out), 64'(vt[i].bcd));
      chk("vec hex", 64'({HEX2, HEX1, HEX0}), 64'({vt[i].h2, vt[i].h1, vt[i].h0}));
      chk("busy at done", 64'(busy), 64'd0);
      @(posedge CLOCK_50); #1;
      chk("done one-cycle", 64'({done, bcd_out}), 64'({1'b0, vt[i].bcd}));
    end

    // start held through conversion; bin_in changes to 99 mid-flight.
    @(negedge CLOCK_50); start = 1'b1; bin_in = 8'd42;
    @(posedge CLOCK_50); #1; start_cnt++;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50); bin_in = 8'd99;
    wait_done(lat);
    chk("held latency", 64'(lat), 64'd7);
    chk("held result 42", 64'(bcd_out), 64'h042);
    @(posedge CLOCK_50); #1; start_cnt++;
    chk("restart after done", 64'({busy, done}), 64'({1'b1, 1'b0}));
    @(negedge CLOCK_50); start = 1'b0;
    wait_done(lat);
    chk("restart latency", 64'(lat), 64'd9);
    chk("restart result 99", 64'({HEX2, HEX1, HEX0, bcd_out}), 64'(ref_all(99)));

    // Reset during the 4th SHIFT cycle discards the conversion.
    @(negedge CLOCK_50); start = 1'b1; bin_in = 8'd200;
    @(posedge CLOCK_50); #1; start = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1; reset = 1'b1; dc = done_cnt;
    @(posedge CLOCK_50); #1;
    chk("mid reset", 64'({busy, done, bcd_out, HEX2, HEX1, HEX0}),
        64'({1'b0, 1'b0, 12'h000, 7'h7f, 7'h7f, 7'h7f}));
    reset = 1'b0;
    repeat (12) @(posedge CLOCK_50);
    #1;
    chk("no done after reset", 64'(done_cnt), 64'(dc));
    chk("idle after reset", 64'(busy), 64'd0);
    convert(13, "post-reset 13");

    // Exhaustive back-to-back sweep.
    for (int v = 0; v < 256; v++) convert(v, "sweep");

    // Random values with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLOCK_50);
      convert(int'($urandom_range(0, 255)), "random");
    end

    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("one done per start", 64'(done_cnt), 64'(start_cnt));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
